// File: rtl/piso6_tx.sv
// Parallel-in/serial-out transmitter: loads a WIDTH-bit word over valid/ready and
// streams it out one bit per accepted beat. Optional even-parity beat: PISO6_PARITY_EN.
module piso6_tx #(
  parameter int WIDTH     = 6,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             ser_ready,
  output logic             ser_valid,
  output logic             ser_out,
  output logic             ser_first,
  output logic             ser_last,
  output logic             busy
);

`ifdef PISO6_PARITY_EN
  localparam int FW = WIDTH + 1;
`else
  localparam int FW = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(FW - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] sh_q, sh_d, load_word;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          accept, beat;

  // Parity rides in the shift register as the final bit, so it drains like data.
  always_comb begin
`ifdef PISO6_PARITY_EN
    if (LSB_FIRST) load_word = {^load_data, load_data};
    else           load_word = {load_data, ^load_data};
`else
    load_word = load_data;
`endif
  end

  assign load_ready = (state_q == IDLE) && rst;
  assign busy       = (state_q == SHIFT);
  assign ser_valid  = valid_q;
  assign ser_first  = first_q;
  assign ser_last   = last_q;
  assign ser_out    = LSB_FIRST ? sh_q[0] : sh_q[FW-1];

  assign accept = load_valid && load_ready;
  assign beat   = valid_q && ser_ready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sh_d    = load_word;
          cnt_d   = '0;
          valid_d = 1'b1;
          first_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (beat) begin
          if (LSB_FIRST) sh_d = {1'b0, sh_q[FW-1:1]};
          else           sh_d = {sh_q[FW-2:0], 1'b0};
          first_d = 1'b0;
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            cnt_d   = '0;
            last_d  = 1'b0;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            last_d = ((cnt_q + CW'(1)) == LAST_CNT);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_piso6_tx.sv
// Scoreboard bench for piso6_tx: stimulus pushes expected {bit,first,last} beats,
// a negedge monitor pops and compares on every accepted serial beat.
module tb_piso6_tx;

  localparam int WIDTH = 6;
`ifdef PISO6_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             ser_ready = 1'b0;
  logic             load_ready, ser_valid, ser_out, ser_first, ser_last, busy;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [2:0] expQ[$];
  logic [2:0] monExp;

  piso6_tx #(.WIDTH(WIDTH), .LSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .ser_ready  (ser_ready),
    .ser_valid  (ser_valid),
    .ser_out    (ser_out),
    .ser_first  (ser_first),
    .ser_last   (ser_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Beats are sampled mid-cycle; the following rising edge is where they are taken.
  always @(negedge clk) begin
    if (rst && ser_valid && ser_ready) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected serial beat", {29'd0, ser_out, ser_first, ser_last}, 32'hFFFF_FFFF);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("serial beat {out,first,last}", {29'd0, ser_out, ser_first, ser_last}, {29'd0, monExp});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushFrame(input logic [WIDTH-1:0] w, input int n);
    logic b;
    for (int i = 0; i < FRAME && i < n; i++) begin
      if (i < WIDTH) b = w[i];
      else           b = ^w;
      expQ.push_back({b, (i == 0), (i == FRAME - 1)});
    end
  endtask

  // Leaves load_valid high; the caller drops it when it no longer wants to offer a word.
  task automatic applyStimulus(input logic [WIDTH-1:0] w, input int nBits, output int acceptCyc);
    int waited;
    load_valid = 1'b1;
    load_data  = w;
    waited     = 0;
    while (!load_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("load_ready within bound", {31'd0, load_ready}, 32'd1);
    pushFrame(w, nBits);
    tick();
    acceptCyc = cyc;
  endtask

  initial begin
    int a0, a1;
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a0, a1;
    rst        = 1'b0;
    load_valid = 1'b1;
    load_data  = 6'h2A;
    ser_ready  = 1'b1;
    tick();
    tick();
    checkOutput("reset load_ready", {31'd0, load_ready}, 32'd0);
    checkOutput("reset ser_valid", {31'd0, ser_valid}, 32'd0);
    checkOutput("reset ser_out", {31'd0, ser_out}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    load_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("post-reset load_ready", {31'd0, load_ready}, 32'd1);
    tick();

    // Basic frame, continuous ready
    applyStimulus(6'b101101, FRAME, a0);
    load_valid = 1'b0;
    checkOutput("first-bit latency ser_valid", {31'd0, ser_valid}, 32'd1);
    checkOutput("busy in frame", {31'd0, busy}, 32'd1);
    checkOutput("load_ready in frame", {31'd0, load_ready}, 32'd0);
    repeat (FRAME) tick();
    checkOutput("basic load_ready after last", {31'd0, load_ready}, 32'd1);
    checkOutput("basic ser_valid after last", {31'd0, ser_valid}, 32'd0);

    // Backpressure at beat 1
    applyStimulus(6'b000011, FRAME, a0);
    load_valid = 1'b0;
    tick();
    ser_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput("stall ser_out", {31'd0, ser_out}, 32'd1);
      checkOutput("stall ser_first", {31'd0, ser_first}, 32'd0);
      checkOutput("stall ser_valid", {31'd0, ser_valid}, 32'd1);
      tick();
    end
    checkOutput("stall ser_out held", {31'd0, ser_out}, 32'd1);
    ser_ready = 1'b1;
    repeat (FRAME - 1) tick();
    checkOutput("backpressure load_ready after last", {31'd0, load_ready}, 32'd1);

    // Back-to-back words with load_valid held high
    applyStimulus(6'h3F, FRAME, a0);
    applyStimulus(6'h00, FRAME, a1);
    load_valid = 1'b0;
    checkOutput("back-to-back accept spacing", a1 - a0, FRAME + 1);
    repeat (FRAME) tick();
    checkOutput("b2b load_ready after last", {31'd0, load_ready}, 32'd1);

    // Mid-frame reset during beat 3 of 6'b111000
    applyStimulus(6'b111000, 3, a0);
    load_valid = 1'b0;
    repeat (3) tick();
    checkOutput("beat3 ser_out before abort", {31'd0, ser_out}, 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("abort ser_valid", {31'd0, ser_valid}, 32'd0);
    checkOutput("abort ser_out", {31'd0, ser_out}, 32'd0);
    checkOutput("abort busy", {31'd0, busy}, 32'd0);
    checkOutput("abort load_ready", {31'd0, load_ready}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("post-abort load_ready", {31'd0, load_ready}, 32'd1);
    tick();
    checkOutput("post-abort ser_valid", {31'd0, ser_valid}, 32'd0);
    applyStimulus(6'b010101, FRAME, a0);
    load_valid = 1'b0;
    repeat (FRAME) tick();
    checkOutput("post-abort frame done", {31'd0, load_ready}, 32'd1);

`ifdef PISO6_PARITY_EN
    // Parity frames: 000111 -> parity 1, 000011 -> parity 0
    applyStimulus(6'b000111, FRAME, a0);
    load_valid = 1'b0;
    repeat (FRAME - 1) tick();
    checkOutput("parity bit odd word", {31'd0, ser_out}, 32'd1);
    checkOutput("parity ser_last", {31'd0, ser_last}, 32'd1);
    tick();
    applyStimulus(6'b000011, FRAME, a0);
    load_valid = 1'b0;
    repeat (FRAME - 1) tick();
    checkOutput("parity bit even word", {31'd0, ser_out}, 32'd0);
    tick();
`endif

    tick();
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/piso6_tx.md
Name: piso6_tx

Overview:
- Parallel-in/serial-out transmitter. Accepts a 6-bit word through a valid/ready load handshake, then emits it one bit per accepted beat on a serial valid/ready stream.
- Counterpart to the team's parallel 6-bit register blocks: this block drains a register word onto a 1-bit link, where the register blocks capture words in parallel.
- Sits between a register or datapath stage and a bit-serial consumer.

Parameters:
- WIDTH, 6: data word width in bits; must be ≥ 2.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit WIDTH-1 first.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous assert, active-low (0 = reset).
- load_valid  in  1  upstream has a word on load_data.
- load_data  in  WIDTH  word to serialize.
- load_ready  out  1  block can accept a word this cycle.
- ser_ready  in  1  downstream accepts the current bit this cycle.
- ser_valid  out  1  ser_out holds a valid bit.
- ser_out  out  1  current serial bit.
- ser_first  out  1  current bit is the first of its frame.
- ser_last  out  1  current bit is the last of its frame.
- busy  out  1  frame in progress (state SHIFT).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, shift register=0, bit counter=0.
- Outputs during reset: ser_out=0, ser_valid=0, ser_first=0, ser_last=0, busy=0, load_ready=0.
- After rst rises, load_ready=1 from the first cycle.
- States: IDLE and SHIFT.
- IDLE:
  - load_ready=1 (combinational from state and rst).
  - ser_valid=0, ser_out=0.
  - Load accept = load_valid & load_ready at a rising edge. On accept: capture load_data into the shift register, counter=0, go to SHIFT.
- SHIFT:
  - load_ready=0; load_valid is ignored.
  - ser_valid=1 from the cycle after accept (latency: 1 cycle from accept edge to first bit).
  - ser_out = shift register LSB (LSB_FIRST=1) or MSB (LSB_FIRST=0).
  - Beat = ser_valid & ser_ready at a rising edge. On a beat: shift by one toward the output end, zero-fill, counter += 1.
  - No beat: ser_out, ser_first, ser_last and counter hold unchanged, for any number of stall cycles.
  - ser_first=1 while counter=0. ser_last=1 while counter=WIDTH-1.
  - Beat with ser_last=1: go to IDLE; ser_valid=0 the next cycle.
- Throughput: a word needs WIDTH beats plus 1 IDLE cycle. Minimum spacing between accepts is WIDTH+1 cycles.
- load_ready never depends on ser_ready (no combinational in-to-out path). Only outputs load_ready and busy are decoded from state; all others come straight from flops.
- Counter width: clog2(WIDTH+1) bits; never wraps in normal operation.
- rst low mid-frame: frame aborts immediately, outputs take reset values, and no further bits of that word are emitted.
- load_valid high during SHIFT: the word is neither captured nor lost by this block; upstream must hold it until load_ready.

Optional Feature:
- Macro: PISO6_PARITY_EN.
- Defined:
  - Frame is WIDTH+1 beats. After the data bits, one even-parity bit is sent: XOR of the captured word, latched at load accept.
  - ser_last asserts on the parity beat only; the counter runs 0..WIDTH.
  - Minimum accept spacing becomes WIDTH+2 cycles.
- Not defined:
  - Frame is exactly WIDTH beats and no parity logic exists.

Test Plan:
- Reset: rst=0 while load_valid=1 -> load_ready=0, ser_valid=0, ser_out=0. After release, load_ready=1 on the next cycle.
- Basic frame, ser_ready=1 constant, LSB_FIRST=1: load 6'b101101 -> ser_out sequence 1,0,1,1,0,1 on consecutive cycles. ser_first on beat 0 only, ser_last on beat 5 only, load_ready=1 the cycle after beat 5.
- Backpressure: load 6'b000011; hold ser_ready=0 for 3 cycles at beat 1 -> ser_out=1 held, ser_first=0, counter unchanged. Sequence resumes 1,0,0,0,0 after ser_ready=1.
- Back-to-back words with load_valid held high: 6'h3F then 6'h00 -> second accept occurs exactly 7 cycles after the first. Serial stream is six 1s, one idle cycle, then six 0s.
- Mid-frame reset: pulse rst low during beat 3 of 6'b111000 -> ser_valid drops asynchronously. After release, the next load of 6'b010101 serializes cleanly from bit 0.
- PISO6_PARITY_EN defined: load 6'b000111 -> ser_out 1,1,1,0,0,0 then parity 1, with ser_last on the 7th beat. Load 6'b000011 -> parity 0.
